// File: rtl/pipeline_sched.sv
// pipeline_sched: pipeline scheduler for the 16-bit five-stage core.
// Sequences stalls, branches, interrupt entry (drain, then vector) and ERET return.
// Optional build macro: SCHED_EXT_INT_EN enables external interrupt acceptance and ext_int_ack.
module pipeline_sched #(
   parameter logic [15:0] INT_VECTOR   = 16'h0008,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] id_addr,
   input  logic        id_pause_req,
   input  logic        id_branch,
   input  logic [15:0] id_new_pc,
   input  logic        id_int,
   input  logic [3:0]  id_int_id,
   input  logic        id_int_en_set,
   input  logic        id_int_en_clr,
   input  logic        ext_int_req,
   input  logic [2:0]  ext_int_id,
   output logic        ext_int_ack,
   output logic        pc_load,
   output logic [15:0] pc_next,
   output logic        pc_hold,
   output logic        ifid_hold,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        int_en,
   output logic [7:0]  cause,
   output logic [15:0] epc
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_VECTOR = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_int_en;
   logic [7:0]       r_cause;
   logic [15:0]      r_epc;

   logic w_eret;
   logic w_soft;
   logic w_ext_req;
   logic w_eret_go;
   logic w_soft_go;
   logic w_ext_go;
   logic w_br_go;

   // External interrupt request qualified by the enable (build option)
`ifdef SCHED_EXT_INT_EN
   assign w_ext_req = r_int_en & ext_int_req;
`else
   logic w_unused_ext;
   assign w_unused_ext = ^{ext_int_req, ext_int_id};
   assign w_ext_req    = 1'b0;
`endif

   // RUN-state decisions in priority order: stall, ERET, soft INT, external INT, branch
   assign w_eret    = id_int & (id_int_id == 4'hF);
   assign w_soft    = id_int & ~w_eret;
   assign w_eret_go = ~id_pause_req & w_eret;
   assign w_soft_go = ~id_pause_req & w_soft;
   assign w_ext_go  = ~id_pause_req & ~id_int & w_ext_req;
   assign w_br_go   = ~id_pause_req & ~id_int & ~w_ext_req & id_branch;

   assign int_en = r_int_en;
   assign cause  = r_cause;
   assign epc    = r_epc;

   // Same-cycle pipeline control from state and ID requests; forced idle during reset
   always_comb begin
      pc_load     = 1'b0;
      pc_next     = 16'h0000;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ext_int_ack = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_RUN: begin
               if (id_pause_req) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  idex_bubble = 1'b1;
               end else if (w_eret_go) begin
                  pc_load    = 1'b1;
                  pc_next    = r_epc;
                  ifid_flush = 1'b1;
               end else if (w_soft_go || w_ext_go) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  pc_hold     = 1'b1;
                  ext_int_ack = w_ext_go;
               end else if (w_br_go) begin
                  pc_load    = 1'b1;
                  pc_next    = id_new_pc;
                  ifid_flush = 1'b1;
               end
            end
            ST_DRAIN: begin
               pc_hold     = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end
            ST_VECTOR: begin
               pc_load    = 1'b1;
               pc_next    = INT_VECTOR;
               ifid_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Scheduler state, drain counter and interrupt state (enable, cause, EPC)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_cnt    <= '0;
         r_int_en <= 1'b0;
         r_cause  <= 8'h00;
         r_epc    <= 16'h0000;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_eret_go) begin
                  r_int_en <= 1'b1;
               end else if (w_soft_go) begin
                  r_epc    <= id_addr + 16'd1;
                  r_cause  <= {4'h0, id_int_id};
                  r_int_en <= 1'b0;
                  r_cnt    <= DRAIN_LOAD;
                  r_state  <= ST_DRAIN;
               end else if (w_ext_go) begin
                  r_epc    <= id_addr;
                  r_cause  <= {5'b10000, ext_int_id};
                  r_int_en <= 1'b0;
                  r_cnt    <= DRAIN_LOAD;
                  r_state  <= ST_DRAIN;
               end else if (!id_pause_req) begin
                  if (id_int_en_clr)
                     r_int_en <= 1'b0;
                  else if (id_int_en_set)
                     r_int_en <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (r_cnt == '0)
                  r_state <= ST_VECTOR;
               else
                  r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_VECTOR: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_sched.sv
// tb_pipeline_sched: scoreboard bench for pipeline_sched (default or SCHED_EXT_INT_EN build).
module tb_pipeline_sched;

   typedef struct packed {
      logic        rst;
      logic [15:0] addr;
      logic        pause;
      logic        branch;
      logic [15:0] new_pc;
      logic        intr;
      logic [3:0]  int_id;
      logic        set;
      logic        clr;
      logic        ext_req;
      logic [2:0]  ext_id;
   } in_t;

   typedef struct packed {
      logic        load;
      logic [15:0] pc_next;
      logic        hold;
      logic        ifh;
      logic        flush;
      logic        bubble;
      logic        ack;
      logic        int_en;
      logic [7:0]  cause;
      logic [15:0] epc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] id_addr = '0;
   logic        id_pause_req = 1'b0;
   logic        id_branch = 1'b0;
   logic [15:0] id_new_pc = '0;
   logic        id_int = 1'b0;
   logic [3:0]  id_int_id = '0;
   logic        id_int_en_set = 1'b0;
   logic        id_int_en_clr = 1'b0;
   logic        ext_int_req = 1'b0;
   logic [2:0]  ext_int_id = '0;
   logic        ext_int_ack;
   logic        pc_load;
   logic [15:0] pc_next;
   logic        pc_hold;
   logic        ifid_hold;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        int_en;
   logic [7:0]  cause;
   logic [15:0] epc;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   string step_name = "";

   // Reference interrupt state visible during the cycle being checked
   logic        m_int_en = 1'b0;
   logic [7:0]  m_cause  = 8'h00;
   logic [15:0] m_epc    = 16'h0000;

   pipeline_sched dut (
      .clk(clk), .rst(rst), .id_addr(id_addr), .id_pause_req(id_pause_req),
      .id_branch(id_branch), .id_new_pc(id_new_pc), .id_int(id_int),
      .id_int_id(id_int_id), .id_int_en_set(id_int_en_set),
      .id_int_en_clr(id_int_en_clr), .ext_int_req(ext_int_req),
      .ext_int_id(ext_int_id), .ext_int_ack(ext_int_ack), .pc_load(pc_load),
      .pc_next(pc_next), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .int_en(int_en),
      .cause(cause), .epc(epc)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s.%s: got %h expected %h at %0t", step_name, tag, got, exp, $time);
      end
   endtask

   function automatic in_t idle();
      in_t v;
      v = '0;
      v.addr = 16'h0200;
      return v;
   endfunction

   function automatic exp_t ex(input logic ld, input logic [15:0] pcn, input logic hold,
                               input logic ifh, input logic fl, input logic bub, input logic ack);
      exp_t e;
      e.load = ld; e.pc_next = pcn; e.hold = hold; e.ifh = ifh;
      e.flush = fl; e.bubble = bub; e.ack = ack;
      e.int_en = m_int_en; e.cause = m_cause; e.epc = m_epc;
      return e;
   endfunction

   function automatic exp_t e_idle();  return ex(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endfunction
   function automatic exp_t e_stall(); return ex(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); endfunction
   function automatic exp_t e_drain(); return ex(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); endfunction
   function automatic exp_t e_load(input logic [15:0] pc);
      return ex(1'b1, pc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction

   // Drive one cycle of stimulus, queue its expectation, then check mid-cycle
   task automatic cycle(input string name, input in_t i, input exp_t e);
      exp_t x;
      @(negedge clk);
      step_name     = name;
      rst           = i.rst;
      id_addr       = i.addr;
      id_pause_req  = i.pause;
      id_branch     = i.branch;
      id_new_pc     = i.new_pc;
      id_int        = i.intr;
      id_int_id     = i.int_id;
      id_int_en_set = i.set;
      id_int_en_clr = i.clr;
      ext_int_req   = i.ext_req;
      ext_int_id    = i.ext_id;
      sb_q.push_back(e);
      #2;
      x = sb_q.pop_front();
      chk("pc_load",     16'(pc_load),     16'(x.load));
      chk("pc_next",     pc_next,          x.pc_next);
      chk("pc_hold",     16'(pc_hold),     16'(x.hold));
      chk("ifid_hold",   16'(ifid_hold),   16'(x.ifh));
      chk("ifid_flush",  16'(ifid_flush),  16'(x.flush));
      chk("idex_bubble", 16'(idex_bubble), 16'(x.bubble));
      chk("ext_int_ack", 16'(ext_int_ack), 16'(x.ack));
      chk("int_en",      16'(int_en),      16'(x.int_en));
      chk("cause",       16'(cause),       16'(x.cause));
      chk("epc",         epc,              x.epc);
   endtask

   initial begin
      in_t v;

      // Reset and idle
      v = idle(); v.rst = 1'b1;
      cycle("reset", v, e_idle());
      cycle("idle0", idle(), e_idle());

      // T1: stall dominates a branch, branch taken once stall drops
      v = idle(); v.pause = 1'b1; v.branch = 1'b1; v.new_pc = 16'h1234;
      cycle("t1_stall", v, e_stall());
      v.pause = 1'b0;
      cycle("t1_branch", v, e_load(16'h1234));

      // MTIH enable
      v = idle(); v.set = 1'b1;
      cycle("mtih_set", v, e_idle());
      m_int_en = 1'b1;
      cycle("en_on", idle(), e_idle());

      // Stall blocks a soft INT: no state change
      v = idle(); v.pause = 1'b1; v.intr = 1'b1; v.int_id = 4'h7;
      cycle("stall_int", v, e_stall());
      cycle("stall_int_after", idle(), e_idle());

      // T2: soft INT 3 at 0x0040, three drain cycles then vector
      v = idle(); v.intr = 1'b1; v.int_id = 4'h3; v.addr = 16'h0040;
      cycle("t2_entry", v, e_drain());
      m_int_en = 1'b0; m_cause = 8'h03; m_epc = 16'h0041;
      v = idle(); v.branch = 1'b1; v.new_pc = 16'hBEEF;
      cycle("t2_drain1", v, e_drain());
      cycle("t2_drain2", idle(), e_drain());
      cycle("t2_drain3", idle(), e_drain());
      cycle("t2_vector", idle(), e_load(16'h0008));
      cycle("t2_run", idle(), e_idle());

      // T3: ERET returns to EPC and re-enables interrupts
      v = idle(); v.intr = 1'b1; v.int_id = 4'hF;
      cycle("t3_eret", v, e_load(16'h0041));
      m_int_en = 1'b1;
      cycle("t3_after", idle(), e_idle());

      // T4: external request with interrupts enabled
      v = idle(); v.ext_req = 1'b1; v.ext_id = 3'd2; v.addr = 16'h0100;
`ifdef SCHED_EXT_INT_EN
      cycle("t4_ext", v, ex(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
      m_int_en = 1'b0; m_cause = 8'h82; m_epc = 16'h0100;
      cycle("t4_drain1", v, e_drain());
      cycle("t4_drain2", v, e_drain());
      cycle("t4_drain3", v, e_drain());
      cycle("t4_vector", v, e_load(16'h0008));
      cycle("t4_noack", v, e_idle());
      v = idle(); v.set = 1'b1;
      cycle("t4_reenable", v, e_idle());
      m_int_en = 1'b1;
`else
      cycle("t4_ext_off", v, e_idle());
      cycle("t4_ext_off2", v, e_idle());
`endif
      cycle("t4_after", idle(), e_idle());

      // T6: clear beats set, then EPC wraps at 0xFFFF
      v = idle(); v.set = 1'b1; v.clr = 1'b1;
      cycle("t6_setclr", v, e_idle());
      m_int_en = 1'b0;
      cycle("t6_off", idle(), e_idle());
      v = idle(); v.intr = 1'b1; v.int_id = 4'h5; v.addr = 16'hFFFF;
      cycle("t6_wrap_entry", v, e_drain());
      m_cause = 8'h05; m_epc = 16'h0000;
      cycle("t6_drain1", idle(), e_drain());

      // T5: reset in the second drain cycle aborts the sequence
      v = idle(); v.rst = 1'b1;
      cycle("t5_rst", v, e_idle());
      m_int_en = 1'b0; m_cause = 8'h00; m_epc = 16'h0000;
      cycle("t5_run", idle(), e_idle());
      cycle("t5_novec", idle(), e_idle());
      cycle("t5_novec2", idle(), e_idle());

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
